// File: rtl/sw_debounce.sv
// sw_debounce -- switch-bank input conditioner.
//
// Brings the asynchronous sw_raw pins into clk through a two-flop
// synchroniser. Each bit is then debounced on its own: a bit's new level is
// accepted only after the synchronised value has disagreed with the current
// debounced level for STABLE_CYCLES consecutive edges.
//
// Optional feature macro: SW_DEBOUNCE_EDGE_EN
//   defined   -> sw_rise / sw_fall carry registered one-cycle edge pulses
//   undefined -> sw_rise / sw_fall are tied to 0 and no pulse flops exist
//
// Ports:
//   clk      system clock, all state on posedge
//   rst      synchronous active-high reset
//   sw_raw   [WIDTH-1:0] raw switch pins (async, may bounce)
//   sw       [WIDTH-1:0] debounced level, registered
//   sw_rise  [WIDTH-1:0] one-cycle pulse on an accepted 0->1
//   sw_fall  [WIDTH-1:0] one-cycle pulse on an accepted 1->0

// Per-bit debounce cell: stability counter, accepted level, edge pulses.
module sw_debounce_bit #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CW            = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic s2,
  output logic sw,
  output logic rise,
  output logic fall
);
  logic [CW-1:0] cnt;
  logic          update;

  // Accept when this edge would be the STABLE_CYCLES-th consecutive
  // disagreement; the counter itself never goes past STABLE_CYCLES-1.
  assign update = (s2 != sw) && (cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sw  <= 1'b0;
    end else if (s2 == sw) begin
      // agreement (incl. a bounce back) restarts the stability window
      cnt <= '0;
    end else if (update) begin
      sw  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= update & s2;
      fall <= update & ~s2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);
  // Counter must hold 0..STABLE_CYCLES-1; keep at least one bit so
  // STABLE_CYCLES=1 still elaborates.
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  logic [WIDTH-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CW           (CW)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .s2  (s2[i]),
      .sw  (sw[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (WIDTH=8, STABLE_CYCLES=4). A behavioural model keeps
// the history of synchronised samples since reset and accepts a new level when
// the last STABLE_CYCLES samples all disagree with the current level. A
// compare process checks the DUT against it every cycle; directed scenarios
// add literal expectations. Pulse expectations follow SW_DEBOUNCE_EDGE_EN.
module tb_sw_debounce;
  localparam int W = 8;
  localparam int S = 4;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw, sw_rise, sw_fall;

  int n_tests = 0;
  int n_fail  = 0;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw     (sw),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_sw = '0, m_rise = '0, m_fall = '0;
  logic [W-1:0] hist[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_s1 = '0; m_s2 = '0; m_sw = '0; m_rise = '0; m_fall = '0;
    end else begin
      // sample seen at this edge by the debounce stage
      hist.push_back(m_s2);
      if (hist.size() > S) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (hist.size() == S) begin
        for (int b = 0; b < W; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (hist[j]) if (hist[j][b] == m_sw[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_sw[b] = ~m_sw[b];
            if (m_sw[b]) m_rise[b] = 1'b1;
            else         m_fall[b] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_raw;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_sw",   sw,      m_sw);
      check("model_rise", sw_rise, EDGE ? m_rise : '0);
      check("model_fall", sw_fall, EDGE ? m_fall : '0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [W-1:0] raw, input int cyc);
    rst = 1'b1; sw_raw = raw;
    step(cyc);
    rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    @(negedge clk);

    // reset with all pins high: 0 during reset, FF 5 edges after release
    do_reset(8'hFF, 3);
    check("rst_sw", sw, 8'h00);
    check("rst_rise", sw_rise, 8'h00);
    step(5);
    check("rst_rel_sw_early", sw, 8'h00);
    step(1);
    check("rst_rel_sw", sw, 8'hFF);
    check("rst_rel_rise", sw_rise, EDGE ? 8'hFF : 8'h00);
    step(1);
    check("rst_rel_rise_gone", sw_rise, 8'h00);

    // clean step on bit 0
    do_reset(8'h00, 2);
    step(8);
    sw_raw = 8'h01;
    step(5);
    check("step_sw_early", sw, 8'h00);
    step(1);
    check("step_sw", sw, 8'h01);
    check("step_rise", sw_rise, EDGE ? 8'h01 : 8'h00);
    check("step_fall", sw_fall, 8'h00);
    step(1);
    check("step_rise_gone", sw_rise, 8'h00);

    // bounce rejection on bit 3
    do_reset(8'h00, 2);
    step(6);
    for (int k = 0; k < 4; k++) begin
      sw_raw = (k % 2 == 0) ? 8'h08 : 8'h00;
      step(1);
    end
    sw_raw = 8'h00;
    step(10);
    check("bounce_sw", sw, 8'h00);

    // bounce then settle on bit 7: 1,1,0,1,1,1...
    sw_raw = 8'h80; step(1);
    sw_raw = 8'h80; step(1);
    sw_raw = 8'h00; step(1);
    sw_raw = 8'h80;
    step(5);
    check("settle_sw_early", sw, 8'h00);
    step(1);
    check("settle_sw", sw, 8'h80);

    // fall plus multi-bit
    do_reset(8'h0F, 2);
    step(10);
    check("multi_pre", sw, 8'h0F);
    sw_raw = 8'hF0;
    step(5);
    check("multi_sw_early", sw, 8'h0F);
    step(1);
    check("multi_sw", sw, 8'hF0);
    check("multi_rise", sw_rise, EDGE ? 8'hF0 : 8'h00);
    check("multi_fall", sw_fall, EDGE ? 8'h0F : 8'h00);

    // reset mid-count
    do_reset(8'h00, 2);
    step(6);
    sw_raw = 8'h01;
    step(2);
    rst = 1'b1;
    step(1);
    check("midrst_sw", sw, 8'h00);
    rst = 1'b0;
    step(5);
    check("midrst_sw_early", sw, 8'h00);
    step(1);
    check("midrst_sw", sw, 8'h01);

    // randomized: noisy bursts alternating with quiet holds, rare resets
    for (int blk = 0; blk < 150; blk++) begin
      for (int c = 0; c < 20; c++) begin
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
        else rst = 1'b0;
        sw_raw = sw_raw ^ W'($urandom & $urandom & $urandom);
        step(1);
      end
      rst = 1'b0;
      if ($urandom_range(0, 2) == 0) sw_raw = W'($urandom);
      step($urandom_range(2, 14));
    end

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input conditioning stage for the NVBoard switch bank. It synchronises the raw `sw` pins into `clk` and debounces each bit independently with a per-bit stability counter. It then presents clean levels, plus optional one-cycle edge pulses, to the downstream LED/display logic, which consumes its `sw` input directly from this block.

## Interface
Parameters:
- `WIDTH`, 8: number of switch bits handled.
- `STABLE_CYCLES`, 1000: cycles a synchronised bit must hold a new value before it is accepted. Legal range is 1..2^20.

Ports:
- `clk`  input  1  system clock. One clock domain, all state on posedge.
- `rst`  input  1  reset, synchronous, active-high.
- `sw_raw`  input  WIDTH  raw switch pins, asynchronous to `clk`, may bounce.
- `sw`  output  WIDTH  debounced level, registered.
- `sw_rise`  output  WIDTH  one-cycle pulse per bit on accepted 0→1, registered.
- `sw_fall`  output  WIDTH  one-cycle pulse per bit on accepted 1→0, registered.

## Operation
- Synchroniser: two flops per bit, `s1 <= sw_raw` then `s2 <= s1`. Only `s2` is used downstream.
- Per bit i there is a counter `cnt[i]` of width `$clog2(STABLE_CYCLES)`, minimum 1 bit. Update rules on each edge:
  - If `s2[i] == sw[i]`, then `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_CYCLES-1`, then `sw[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else `cnt[i] <= cnt[i] + 1`.
- A bounce that returns `s2[i]` to `sw[i]` clears the counter. Stability is measured from the last disagreement start, not accumulated.
- Bits are fully independent. Simultaneous changes on several bits are accepted on the same edge when their histories match.
- Edge pulses are registered on the same edge that updates `sw[i]`:
  - `sw_rise[i] <= update & s2[i]`
  - `sw_fall[i] <= update & ~s2[i]`
  - Both pulses are 0 on every other cycle.
- No saturation or wrap: the counter never exceeds `STABLE_CYCLES-1`.

## Timing
- Reset: `s1`, `s2`, `cnt`, `sw`, `sw_rise`, and `sw_fall` are all 0 after any `clk` edge with `rst`=1. Reset asserted mid-count discards the count.
- Latency: a level on `sw_raw` is sampled at edge 0 and held thereafter. `sw` changes at edge `STABLE_CYCLES+1`, and the matching pulse is high for exactly the cycle following that edge.
- Because reset value of `sw` is 0, a bit held 1 through reset release produces `sw`=1 and a `sw_rise` pulse `STABLE_CYCLES+1` edges after release.
- A glitch lasting fewer than `STABLE_CYCLES` cycles at `s2` produces no change and no pulse.
- Minimum spacing between two accepted transitions on one bit is `STABLE_CYCLES` cycles. Consecutive pulses on one bit are therefore never adjacent for `STABLE_CYCLES`≥2.

## Configuration
- Macro: `SW_DEBOUNCE_EDGE_EN`.
- When defined, the edge-pulse registers are built as in Operation.
- When undefined, `sw_rise` and `sw_fall` remain as ports tied to constant 0, and no pulse flops are inferred. `sw` behaviour is identical in both builds.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `WIDTH`=8.
- Reset check: hold `rst`=1 for 3 cycles with `sw_raw`=8'hFF, then release → `sw`=8'h00 during reset. `sw` becomes 8'hFF exactly 5 edges after the first non-reset edge, and `sw_rise`=8'hFF for one cycle (macro defined).
- Clean step: from all-0, set `sw_raw[0]`=1 before edge 0 → `sw[0]`=1 after edge 5 and `sw_rise[0]` high only in cycle 5→6. Other bits and `sw_fall` stay 0.
- Bounce rejection: toggle `sw_raw[3]` 1,0,1,0 on alternate cycles, then hold 0 → `sw`, `sw_rise`, and `sw_fall` stay 0 throughout.
- Bounce then settle: `sw_raw[7]` pattern 1,1,0,1,1,1,1,… → `sw[7]` rises 5 edges after the final 0→1 reaches `sw_raw`, not earlier.
- Fall plus multi-bit: with `sw`=8'h0F, drive `sw_raw`=8'hF0 → after edge 5, `sw`=8'hF0 with `sw_rise`=8'hF0 and `sw_fall`=8'h0F in the same cycle. Build without `SW_DEBOUNCE_EDGE_EN`: same `sw`, pulses constant 0.
- Reset mid-count: assert `rst` 2 cycles after a raw change, then deassert with raw still changed → counting restarts, and `sw` updates 5 edges after release.
